// File: rtl/noc_host_ni.sv
// Host network interface for one ring NoC node: packetizes and paces host writes
// into the router input port, and filters and buffers ejected packets for the host.
module noc_host_ni #(
  parameter int NODE_ID     = 0,
  parameter int PACKET_SIZE = 8,
  parameter int ROUTER_BITS = 2,
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 4,
  parameter int TX_GAP      = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              host_tx_valid,
  output logic                              host_tx_ready,
  input  logic [ROUTER_BITS-1:0]            host_tx_dest,
  input  logic [PACKET_SIZE-ROUTER_BITS-1:0] host_tx_payload,
  output logic [PACKET_SIZE-1:0]            net_data_out,
  output logic                              net_enable_out,
  input  logic                              net_in_full,
  input  logic [PACKET_SIZE-1:0]            net_data_in,
  input  logic                              net_enable_in,
  output logic                              net_out_full,
  output logic                              host_rx_valid,
  input  logic                              host_rx_ready,
  output logic [PACKET_SIZE-ROUTER_BITS-1:0] host_rx_payload,
  output logic                              host_rx_src_ok,
  output logic [7:0]                        misroute_cnt,
  output logic [7:0]                        overflow_cnt
);

  localparam int PW  = PACKET_SIZE - ROUTER_BITS;
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int RCW = RAW + 1;

  localparam logic [ROUTER_BITS-1:0] NODE_ADDR = ROUTER_BITS'(NODE_ID);
  localparam logic [2:0]             GAP_LOAD  = 3'(TX_GAP);
  localparam logic                   SRC_OK    = (NODE_ID >= 0) && (NODE_ID < (1 << ROUTER_BITS));
  localparam logic [TCW-1:0]         TX_FULL_LVL = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0]         RX_FULL_LVL = RCW'(RX_DEPTH);
  localparam logic [RCW-1:0]         RX_WARN_LVL = RCW'(RX_DEPTH - 1);

  typedef enum logic {IDLE, HOLD} tx_state_t;

  assign host_rx_src_ok = SRC_OK;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [PACKET_SIZE-1:0] tx_mem [TX_DEPTH];
  logic [TAW-1:0]         tx_wr_ptr, tx_rd_ptr;
  logic [TCW-1:0]         tx_count;
  logic                   tx_full, tx_empty, tx_push, tx_pop;

  assign tx_full       = (tx_count == TX_FULL_LVL);
  assign tx_empty      = (tx_count == '0);
  assign host_tx_ready = !tx_full && !rst;
  assign tx_push       = host_tx_valid && host_tx_ready;

  // NOTE: storage arrays carry no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= {host_tx_payload, host_tx_dest};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      unique case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // TX injection FSM: one strobe, then TX_GAP forced idle cycles
  // ---------------------------------------------------------------------------
  tx_state_t  tx_state, tx_state_next;
  logic [2:0] gap_cnt, gap_cnt_next;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    tx_state_next = tx_state;
    gap_cnt_next  = gap_cnt;
    tx_pop        = 1'b0;
    unique case (tx_state)
      IDLE: begin
        if (!tx_empty && !net_in_full) begin
          tx_pop = 1'b1;
          if (GAP_LOAD != 3'd0) begin
            tx_state_next = HOLD;
            gap_cnt_next  = GAP_LOAD;
          end
        end
      end
      HOLD: begin
        gap_cnt_next = gap_cnt - 3'd1;
        if (gap_cnt <= 3'd1) tx_state_next = IDLE;
      end
      default: tx_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state       <= IDLE;
      gap_cnt        <= '0;
      net_enable_out <= 1'b0;
      net_data_out   <= '0;
    end else begin
      tx_state       <= tx_state_next;
      gap_cnt        <= gap_cnt_next;
      net_enable_out <= tx_pop;
      if (tx_pop) net_data_out <= tx_mem[tx_rd_ptr];
    end
  end

  // ---------------------------------------------------------------------------
  // RX filter and FIFO
  // ---------------------------------------------------------------------------
  logic [PW-1:0]  rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RCW-1:0] rx_count, rx_count_next;
  logic           rx_full, rx_empty, rx_push, rx_pop;
  logic           dest_match, rx_misroute, rx_overflow;

  assign dest_match      = (net_data_in[ROUTER_BITS-1:0] == NODE_ADDR);
  assign rx_full         = (rx_count == RX_FULL_LVL);
  assign rx_empty        = (rx_count == '0);
  assign host_rx_valid   = !rx_empty;
  assign host_rx_payload = rx_mem[rx_rd_ptr];
  assign rx_pop          = host_rx_valid && host_rx_ready;
  // A full FIFO still accepts a packet when the host frees the head slot in the same cycle.
  assign rx_push         = net_enable_in && dest_match && (!rx_full || rx_pop);
  assign rx_overflow     = net_enable_in && dest_match && rx_full && !rx_pop;
  assign rx_misroute     = net_enable_in && !dest_match;

  always_comb begin
    rx_count_next = rx_count;
    unique case ({rx_push, rx_pop})
      2'b10:   rx_count_next = rx_count + 1'b1;
      2'b01:   rx_count_next = rx_count - 1'b1;
      default: rx_count_next = rx_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= net_data_in[PACKET_SIZE-1:ROUTER_BITS];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr    <= '0;
      rx_rd_ptr    <= '0;
      rx_count     <= '0;
      net_out_full <= 1'b0;
      misroute_cnt <= '0;
      overflow_cnt <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_count     <= rx_count_next;
      // One slot of slack absorbs a packet the router launched before seeing the flag.
      net_out_full <= (rx_count_next >= RX_WARN_LVL);
      if (rx_misroute && misroute_cnt != 8'hFF) misroute_cnt <= misroute_cnt + 8'd1;
      if (rx_overflow && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_noc_host_ni.sv
// Directed self-checking bench for noc_host_ni (NODE_ID=1, depths 4, TX_GAP=2).
module tb_noc_host_ni;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_tx_valid;
  logic       host_tx_ready;
  logic [1:0] host_tx_dest;
  logic [5:0] host_tx_payload;
  logic [7:0] net_data_out;
  logic       net_enable_out;
  logic       net_in_full;
  logic [7:0] net_data_in;
  logic       net_enable_in;
  logic       net_out_full;
  logic       host_rx_valid;
  logic       host_rx_ready;
  logic [5:0] host_rx_payload;
  logic       host_rx_src_ok;
  logic [7:0] misroute_cnt;
  logic [7:0] overflow_cnt;

  int errors = 0;
  int checks = 0;

  noc_host_ni #(
    .NODE_ID(1), .PACKET_SIZE(8), .ROUTER_BITS(2),
    .TX_DEPTH(4), .RX_DEPTH(4), .TX_GAP(2)
  ) dut (
    .clk(clk), .rst(rst),
    .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
    .host_tx_dest(host_tx_dest), .host_tx_payload(host_tx_payload),
    .net_data_out(net_data_out), .net_enable_out(net_enable_out),
    .net_in_full(net_in_full), .net_data_in(net_data_in),
    .net_enable_in(net_enable_in), .net_out_full(net_out_full),
    .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
    .host_rx_payload(host_rx_payload), .host_rx_src_ok(host_rx_src_ok),
    .misroute_cnt(misroute_cnt), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enable_out"}, 32'(net_enable_out), 32'd0);
    check({tag, "_data_out"},   32'(net_data_out),   32'h00);
    check({tag, "_out_full"},   32'(net_out_full),   32'd0);
    check({tag, "_rx_valid"},   32'(host_rx_valid),  32'd0);
    check({tag, "_misroute"},   32'(misroute_cnt),   32'd0);
    check({tag, "_overflow"},   32'(overflow_cnt),   32'd0);
  endtask

  initial begin
    logic [7:0] bp_pkts [4];
    int         strobe_idx [4];
    logic [7:0] strobe_data [4];
    int         n_strobes;

    bp_pkts = '{8'h40, 8'h45, 8'h4A, 8'h4F};

    rst = 1'b1;
    host_tx_valid = 1'b0; host_tx_dest = '0; host_tx_payload = '0;
    net_in_full = 1'b0; net_data_in = '0; net_enable_in = 1'b0;
    host_rx_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_tx_ready", 32'(host_tx_ready), 32'd0);
    check("src_ok", 32'(host_rx_src_ok), 32'd1);
    check_reset_outputs("rst");
    rst = 1'b0;
    #1;
    check("post_rst_tx_ready", 32'(host_tx_ready), 32'd1);
    tick();

    // Single packet: dest=2 payload=0x15 -> 0x56, then two idle cycles
    host_tx_valid = 1'b1; host_tx_dest = 2'd2; host_tx_payload = 6'h15;
    tick();
    host_tx_valid = 1'b0;
    check("single_latency_low", 32'(net_enable_out), 32'd0);
    tick();
    check("single_strobe", 32'(net_enable_out), 32'd1);
    check("single_data", 32'(net_data_out), 32'h56);
    tick();
    check("single_gap1", 32'(net_enable_out), 32'd0);
    tick();
    check("single_gap2", 32'(net_enable_out), 32'd0);
    check("single_data_hold", 32'(net_data_out), 32'h56);
    tick();

    // Backpressure: four packets queued while the router is full
    net_in_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_tx_valid = 1'b1;
      host_tx_dest = 2'(i);
      host_tx_payload = 6'h10 + 6'(i);
      tick();
      check($sformatf("bp_no_strobe_%0d", i), 32'(net_enable_out), 32'd0);
    end
    host_tx_valid = 1'b0;
    check("bp_tx_ready_full", 32'(host_tx_ready), 32'd0);
    tick(); tick();
    check("bp_still_blocked", 32'(net_enable_out), 32'd0);
    net_in_full = 1'b0;
    n_strobes = 0;
    for (int c = 0; c < 13; c++) begin
      tick();
      if (net_enable_out) begin
        if (n_strobes < 4) begin
          strobe_idx[n_strobes] = c;
          strobe_data[n_strobes] = net_data_out;
        end
        n_strobes++;
      end
    end
    check("bp_strobe_count", 32'(n_strobes), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < n_strobes) begin
        check($sformatf("bp_spacing_%0d", i), 32'(strobe_idx[i]), 32'(3 * i));
        check($sformatf("bp_order_%0d", i), 32'(strobe_data[i]), 32'(bp_pkts[i]));
      end
    end
    check("bp_tx_ready_drained", 32'(host_tx_ready), 32'd1);

    // Receive a packet addressed to node 1
    net_enable_in = 1'b1; net_data_in = 8'h29;
    tick();
    net_enable_in = 1'b0;
    check("rx_valid", 32'(host_rx_valid), 32'd1);
    check("rx_payload", 32'(host_rx_payload), 32'h0A);
    check("rx_out_full", 32'(net_out_full), 32'd0);
    host_rx_ready = 1'b1;
    tick();
    host_rx_ready = 1'b0;
    check("rx_consumed", 32'(host_rx_valid), 32'd0);

    // Misroute: dest 2 at node 1
    net_enable_in = 1'b1; net_data_in = 8'h2A;
    tick();
    net_enable_in = 1'b0;
    check("misroute_cnt", 32'(misroute_cnt), 32'd1);
    check("misroute_dropped", 32'(host_rx_valid), 32'd0);

    // RX overflow: five back-to-back packets, host stalled
    for (int i = 1; i <= 5; i++) begin
      net_enable_in = 1'b1;
      net_data_in = {6'(i), 2'd1};
      tick();
      if (i == 2) check("ovf_full_after2", 32'(net_out_full), 32'd0);
      if (i == 3) check("ovf_full_after3", 32'(net_out_full), 32'd1);
    end
    net_enable_in = 1'b0;
    check("ovf_cnt", 32'(overflow_cnt), 32'd1);
    host_rx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_valid_%0d", i), 32'(host_rx_valid), 32'd1);
      check($sformatf("drain_payload_%0d", i), 32'(host_rx_payload), 32'(i));
      tick();
      if (i == 1) check("drain_full_at3", 32'(net_out_full), 32'd1);
      if (i == 2) check("drain_full_at2", 32'(net_out_full), 32'd0);
    end
    host_rx_ready = 1'b0;
    check("drain_empty", 32'(host_rx_valid), 32'd0);

    // Full FIFO: push and pop in the same cycle both succeed
    for (int i = 6; i <= 9; i++) begin
      net_enable_in = 1'b1;
      net_data_in = {6'(i), 2'd1};
      tick();
    end
    net_data_in = {6'd10, 2'd1};
    host_rx_ready = 1'b1;
    tick();
    net_enable_in = 1'b0;
    check("full_pushpop_ovf", 32'(overflow_cnt), 32'd1);
    check("full_pushpop_head", 32'(host_rx_payload), 32'd7);
    for (int i = 7; i <= 10; i++) begin
      check($sformatf("full_pushpop_payload_%0d", i), 32'(host_rx_payload), 32'(i));
      tick();
    end
    host_rx_ready = 1'b0;
    check("full_pushpop_empty", 32'(host_rx_valid), 32'd0);

    // Mid-HOLD reset: second queued packet must never leave
    host_tx_valid = 1'b1; host_tx_dest = 2'd3; host_tx_payload = 6'h2A;
    tick();
    host_tx_dest = 2'd0; host_tx_payload = 6'h01;
    tick();
    host_tx_valid = 1'b0;
    check("hold_strobe", 32'(net_enable_out), 32'd1);
    check("hold_data", 32'(net_data_out), 32'hAB);
    rst = 1'b1;
    tick();
    check("hold_rst_tx_ready", 32'(host_tx_ready), 32'd0);
    check_reset_outputs("hold_rst");
    rst = 1'b0;
    #1;
    check("hold_post_tx_ready", 32'(host_tx_ready), 32'd1);
    n_strobes = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (net_enable_out) n_strobes++;
    end
    check("hold_queue_discarded", 32'(n_strobes), 32'd0);

    // Counter saturation
    net_enable_in = 1'b1; net_data_in = 8'h03;
    for (int i = 0; i < 260; i++) tick();
    net_enable_in = 1'b0;
    check("misroute_saturate", 32'(misroute_cnt), 32'd255);
    check("saturate_no_rx", 32'(host_rx_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
